// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard/stall sequencer for the 5-stage IF/ID/EX/MEM/WB datapath. It detects
// load-use hazards, sequences the IF/ID flush after a taken branch, and freezes
// the whole pipe while data memory is busy. It also produces the EX-stage
// forwarding selects.
//
// Configuration macro:
//   HAZARD_PERF_CNT_EN  when defined, stall_cnt/flush_cnt/wait_cnt count cycles
//                       of load-use stall, IFID_flush and memory freeze, and
//                       saturate at all-ones. When undefined, the counters are
//                       not built and the outputs are tied to zero.
//
// Ports:
//   clk, reset                       rising-edge clock, async active-high reset
//   IFID_rs1/IFID_rs2                sources of the instruction in ID
//   IDEX_rs1/IDEX_rs2/IDEX_rd        sources/destination of the instruction in EX
//   IDEX_MemRead                     EX instruction is a load
//   EXMEM_rd/EXMEM_RegWrite          destination and write flag in MEM
//   MEMWB_rd/MEMWB_RegWrite          destination and write flag in WB
//   branch_taken                     taken branch resolved in EX
//   mem_req/mem_ready                data-memory access and completion
//   PC_write..EXMEM_write            stage-register write enables
//   IFID_flush/IDEX_bubble/MEMWB_bubble  NOP insertion controls
//   ForwardA/ForwardB                00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt/flush_cnt/wait_cnt     performance counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; load-use detection active
// MEM_WAIT | pipe frozen until data memory reports ready
// FLUSH    | post-branch IF/ID flush; flush_ctr cycles remain
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] IFID_rs1,
    input  logic [REG_AW-1:0] IFID_rs2,
    input  logic [REG_AW-1:0] IDEX_rs1,
    input  logic [REG_AW-1:0] IDEX_rs2,
    input  logic [REG_AW-1:0] IDEX_rd,
    input  logic              IDEX_MemRead,
    input  logic [REG_AW-1:0] EXMEM_rd,
    input  logic              EXMEM_RegWrite,
    input  logic [REG_AW-1:0] MEMWB_rd,
    input  logic              MEMWB_RegWrite,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              PC_write,
    output logic              IFID_write,
    output logic              IDEX_write,
    output logic              EXMEM_write,
    output logic              IFID_flush,
    output logic              IDEX_bubble,
    output logic              MEMWB_bubble,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  wait_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    // Branch cycle itself flushes once, the rest is counted down in FLUSH.
    localparam logic [1:0] FLUSH_LOAD = 2'(BR_PENALTY - 1);

    state_t     state, state_nxt;
    logic [1:0] flush_ctr, flush_ctr_nxt;

    logic freeze;
    logic flush_mode;
    logic do_branch;
    logic load_use_hit;
    logic do_stall;

    // In MEM_WAIT the access is already outstanding, so only mem_ready matters.
    assign freeze = (state == S_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

    // flush_ctr is non-zero only in FLUSH, or in MEM_WAIT when the freeze
    // interrupted a flush; the release cycle then behaves as FLUSH.
    assign flush_mode = (flush_ctr != 2'd0);

    assign do_branch = branch_taken && !freeze;

    assign load_use_hit = IDEX_MemRead && (IDEX_rd != '0) &&
                          ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

    assign do_stall = load_use_hit && !freeze && !do_branch && !flush_mode;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            flush_ctr <= 2'd0;
        end else begin
            state     <= state_nxt;
            flush_ctr <= flush_ctr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        flush_ctr_nxt = flush_ctr;
        if (freeze) begin
            state_nxt = S_MEM_WAIT;
        end else if (do_branch) begin
            flush_ctr_nxt = FLUSH_LOAD;
            state_nxt     = (FLUSH_LOAD != 2'd0) ? S_FLUSH : S_RUN;
        end else if (flush_mode) begin
            flush_ctr_nxt = flush_ctr - 2'd1;
            state_nxt     = (flush_ctr == 2'd1) ? S_RUN : S_FLUSH;
        end else begin
            state_nxt = S_RUN;
        end
    end

    // Output logic
    always_comb begin
        PC_write     = 1'b1;
        IFID_write   = 1'b1;
        IDEX_write   = 1'b1;
        EXMEM_write  = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_bubble  = 1'b0;
        MEMWB_bubble = 1'b0;
        if (reset) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_write  = 1'b0;
            IFID_flush   = 1'b1;
            IDEX_bubble  = 1'b1;
            MEMWB_bubble = 1'b1;
        end else if (freeze) begin
            // Held registers keep their contents; only WB gets a bubble.
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_write  = 1'b0;
            MEMWB_bubble = 1'b1;
        end else if (do_branch) begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (flush_mode) begin
            IFID_flush = 1'b1;
        end else if (do_stall) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end
    end

    // Forwarding: the younger producer (EX/MEM) wins; x0 is never forwarded.
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (!reset) begin
            if (EXMEM_RegWrite && (EXMEM_rd != '0) && (EXMEM_rd == IDEX_rs1))
                ForwardA = 2'b10;
            else if (MEMWB_RegWrite && (MEMWB_rd != '0) && (MEMWB_rd == IDEX_rs1))
                ForwardA = 2'b01;

            if (EXMEM_RegWrite && (EXMEM_rd != '0) && (EXMEM_rd == IDEX_rs2))
                ForwardB = 2'b10;
            else if (MEMWB_RegWrite && (MEMWB_rd != '0) && (MEMWB_rd == IDEX_rs2))
                ForwardB = 2'b01;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (do_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (IFID_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (freeze && (wait_cnt != '1))
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {PC_write, IFID_write, IDEX_write, EXMEM_write,
    //  IFID_flush, IDEX_bubble, MEMWB_bubble, ForwardA, ForwardB}
    localparam logic [10:0] C_RUN   = 11'b1111_000_0000;
    localparam logic [10:0] C_STALL = 11'b0011_010_0000;
    localparam logic [10:0] C_BR    = 11'b1111_110_0000;
    localparam logic [10:0] C_FL    = 11'b1111_100_0000;
    localparam logic [10:0] C_FRZ   = 11'b0000_001_0000;
    localparam logic [10:0] C_RST   = 11'b0000_111_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] IFID_rs1, IFID_rs2, IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic              IDEX_MemRead;
    logic [REG_AW-1:0] EXMEM_rd, MEMWB_rd;
    logic              EXMEM_RegWrite, MEMWB_RegWrite;
    logic              branch_taken, mem_req, mem_ready;
    logic              PC_write, IFID_write, IDEX_write, EXMEM_write;
    logic              IFID_flush, IDEX_bubble, MEMWB_bubble;
    logic [1:0]        ForwardA, ForwardB;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt, wait_cnt;

    logic [10:0]        ctrl;
    logic [3*CNT_W-1:0] cnt_obs, cnt_exp;

    int vecs = 0;
    int errs = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int exp_wait  = 0;

    assign ctrl = {PC_write, IFID_write, IDEX_write, EXMEM_write,
                   IFID_flush, IDEX_bubble, MEMWB_bubble, ForwardA, ForwardB};
    assign cnt_obs = {stall_cnt, flush_cnt, wait_cnt};

    pipeline_hazard_ctrl #(
        .REG_AW(REG_AW), .BR_PENALTY(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
        .IDEX_MemRead(IDEX_MemRead),
        .EXMEM_rd(EXMEM_rd), .EXMEM_RegWrite(EXMEM_RegWrite),
        .MEMWB_rd(MEMWB_rd), .MEMWB_RegWrite(MEMWB_RegWrite),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
        .EXMEM_write(EXMEM_write), .IFID_flush(IFID_flush),
        .IDEX_bubble(IDEX_bubble), .MEMWB_bubble(MEMWB_bubble),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        IFID_rs1 = '0; IFID_rs2 = '0;
        IDEX_rs1 = '0; IDEX_rs2 = '0; IDEX_rd = '0; IDEX_MemRead = 1'b0;
        EXMEM_rd = '0; EXMEM_RegWrite = 1'b0;
        MEMWB_rd = '0; MEMWB_RegWrite = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Move to the next cycle; inputs are changed 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cnt_exp();
        cnt_exp = PERF ? {CNT_W'(exp_stall), CNT_W'(exp_flush), CNT_W'(exp_wait)} : '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        branch_taken = 1'b1; EXMEM_rd = 5'd3; EXMEM_RegWrite = 1'b1; IDEX_rs1 = 5'd3;
        #2;
        if (ctrl !== C_RST) begin
            $display("FAIL reset_outputs: ctrl=%b expected %b", ctrl, C_RST); errs++;
        end
        vecs++;
        cyc();
        set_cnt_exp();
        if (cnt_obs !== cnt_exp) begin
            $display("FAIL reset_counters: cnt=%h expected %h", cnt_obs, cnt_exp); errs++;
        end
        vecs++;
        idle();
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        cyc(); idle();
        IFID_rs1 = 5'd5; IFID_rs2 = 5'd1; IDEX_rd = 5'd5; IDEX_MemRead = 1'b1;
        #2;
        if (ctrl !== C_STALL) begin
            $display("FAIL lu_stall: ctrl=%b expected %b", ctrl, C_STALL); errs++;
        end
        vecs++;
        exp_stall++;
        cyc();
        IDEX_rd = '0; IDEX_MemRead = 1'b0; EXMEM_rd = 5'd5; EXMEM_RegWrite = 1'b1;
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL lu_one_cycle: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        cyc(); idle();
        MEMWB_rd = 5'd5; MEMWB_RegWrite = 1'b1; IDEX_rs1 = 5'd5; IDEX_rs2 = 5'd1;
        #2;
        if (ctrl !== 11'b1111_000_0100) begin
            $display("FAIL lu_fwd_memwb: ctrl=%b expected %b", ctrl, 11'b1111_000_0100); errs++;
        end
        vecs++;
        cyc(); idle();
        IDEX_MemRead = 1'b1; IDEX_rd = '0; IFID_rs1 = '0;
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL lu_x0: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        cyc(); idle();
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd7; IFID_rs2 = 5'd7;
        #2;
        if (ctrl !== C_STALL) begin
            $display("FAIL lu_rs2: ctrl=%b expected %b", ctrl, C_STALL); errs++;
        end
        vecs++;
        exp_stall++;
        cyc(); idle();
        IDEX_rd = 5'd7; IFID_rs1 = 5'd7;
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL lu_not_load: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        cyc(); idle();
        set_cnt_exp();
        if (cnt_obs !== cnt_exp) begin
            $display("FAIL lu_counters: cnt=%h expected %h", cnt_obs, cnt_exp); errs++;
        end
        vecs++;
    endtask

    task automatic test_forwarding();
        cyc(); idle();
        IDEX_rs1 = 5'd3; IDEX_rs2 = 5'd3;
        EXMEM_rd = 5'd3; EXMEM_RegWrite = 1'b1; MEMWB_rd = 5'd3; MEMWB_RegWrite = 1'b1;
        #2;
        if (ctrl !== 11'b1111_000_1010) begin
            $display("FAIL fwd_exmem: ctrl=%b expected %b", ctrl, 11'b1111_000_1010); errs++;
        end
        vecs++;
        cyc(); idle();
        EXMEM_RegWrite = 1'b1; MEMWB_RegWrite = 1'b1;
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL fwd_x0: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        cyc(); idle();
        EXMEM_rd = 5'd3; MEMWB_rd = 5'd4; MEMWB_RegWrite = 1'b1;
        IDEX_rs1 = 5'd3; IDEX_rs2 = 5'd4;
        #2;
        if (ctrl !== 11'b1111_000_0001) begin
            $display("FAIL fwd_b_memwb: ctrl=%b expected %b", ctrl, 11'b1111_000_0001); errs++;
        end
        vecs++;
    endtask

    task automatic test_branch();
        cyc(); idle();
        branch_taken = 1'b1;
        #2;
        if (ctrl !== C_BR) begin
            $display("FAIL br_first: ctrl=%b expected %b", ctrl, C_BR); errs++;
        end
        vecs++;
        cyc(); idle();
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; IFID_rs1 = 5'd5;
        #2;
        if (ctrl !== C_FL) begin
            $display("FAIL br_second: ctrl=%b expected %b", ctrl, C_FL); errs++;
        end
        vecs++;
        exp_flush += 2;
        cyc(); idle();
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL br_done: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        set_cnt_exp();
        if (cnt_obs !== cnt_exp) begin
            $display("FAIL br_counters: cnt=%h expected %h", cnt_obs, cnt_exp); errs++;
        end
        vecs++;
    endtask

    task automatic test_mem_wait();
        cyc(); idle();
        mem_req = 1'b1;
        #2;
        if (ctrl !== C_FRZ) begin
            $display("FAIL mw_first: ctrl=%b expected %b", ctrl, C_FRZ); errs++;
        end
        vecs++;
        cyc();
        branch_taken = 1'b1;
        #2;
        if (ctrl !== C_FRZ) begin
            $display("FAIL mw_branch_ignored: ctrl=%b expected %b", ctrl, C_FRZ); errs++;
        end
        vecs++;
        cyc();
        branch_taken = 1'b0;
        #2;
        if (ctrl !== C_FRZ) begin
            $display("FAIL mw_third: ctrl=%b expected %b", ctrl, C_FRZ); errs++;
        end
        vecs++;
        exp_wait += 3;
        cyc();
        mem_ready = 1'b1;
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL mw_release: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        cyc(); idle();
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL mw_back_to_run: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        set_cnt_exp();
        if (cnt_obs !== cnt_exp) begin
            $display("FAIL mw_counters: cnt=%h expected %h", cnt_obs, cnt_exp); errs++;
        end
        vecs++;
    endtask

    task automatic test_branch_load_use();
        cyc(); idle();
        branch_taken = 1'b1; IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; IFID_rs1 = 5'd5;
        #2;
        if (ctrl !== C_BR) begin
            $display("FAIL bl_branch_wins: ctrl=%b expected %b", ctrl, C_BR); errs++;
        end
        vecs++;
        cyc(); idle();
        #2;
        if (ctrl !== C_FL) begin
            $display("FAIL bl_flush: ctrl=%b expected %b", ctrl, C_FL); errs++;
        end
        vecs++;
        exp_flush += 2;
        cyc();
        set_cnt_exp();
        if (cnt_obs !== cnt_exp) begin
            $display("FAIL bl_counters: cnt=%h expected %h", cnt_obs, cnt_exp); errs++;
        end
        vecs++;
    endtask

    task automatic test_flush_freeze();
        cyc(); idle();
        branch_taken = 1'b1;
        #2;
        if (ctrl !== C_BR) begin
            $display("FAIL ff_branch: ctrl=%b expected %b", ctrl, C_BR); errs++;
        end
        vecs++;
        cyc(); idle();
        mem_req = 1'b1;
        #2;
        if (ctrl !== C_FRZ) begin
            $display("FAIL ff_frozen: ctrl=%b expected %b", ctrl, C_FRZ); errs++;
        end
        vecs++;
        cyc();
        mem_ready = 1'b1;
        #2;
        if (ctrl !== C_FL) begin
            $display("FAIL ff_resume_flush: ctrl=%b expected %b", ctrl, C_FL); errs++;
        end
        vecs++;
        exp_flush += 2;
        exp_wait  += 1;
        cyc(); idle();
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL ff_done: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        set_cnt_exp();
        if (cnt_obs !== cnt_exp) begin
            $display("FAIL ff_counters: cnt=%h expected %h", cnt_obs, cnt_exp); errs++;
        end
        vecs++;
    endtask

    task automatic test_reset_mid_op();
        cyc(); idle();
        mem_req = 1'b1;
        cyc();
        #2;
        if (ctrl !== C_FRZ) begin
            $display("FAIL rm_in_wait: ctrl=%b expected %b", ctrl, C_FRZ); errs++;
        end
        vecs++;
        #1 reset = 1'b1;
        #1;
        if (ctrl !== C_RST) begin
            $display("FAIL rm_async: ctrl=%b expected %b", ctrl, C_RST); errs++;
        end
        vecs++;
        exp_stall = 0; exp_flush = 0; exp_wait = 0;
        cyc();
        reset = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL rm_run_after_wait: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        set_cnt_exp();
        if (cnt_obs !== cnt_exp) begin
            $display("FAIL rm_counters: cnt=%h expected %h", cnt_obs, cnt_exp); errs++;
        end
        vecs++;
        cyc(); idle();
        branch_taken = 1'b1;
        cyc(); idle();
        #1 reset = 1'b1;
        #1;
        if (ctrl !== C_RST) begin
            $display("FAIL rm_async_flush: ctrl=%b expected %b", ctrl, C_RST); errs++;
        end
        vecs++;
        cyc();
        reset = 1'b0;
        #2;
        if (ctrl !== C_RUN) begin
            $display("FAIL rm_run_after_flush: ctrl=%b expected %b", ctrl, C_RUN); errs++;
        end
        vecs++;
        cyc();
        set_cnt_exp();
        if (cnt_obs !== cnt_exp) begin
            $display("FAIL rm_counters_flush: cnt=%h expected %h", cnt_obs, cnt_exp); errs++;
        end
        vecs++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mem_wait();
        test_branch_load_use();
        test_flush_freeze();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
